// File: rtl/mips_mc_ctrl.sv
// Multi-cycle control sequencer for the MIPS core: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the shared datapath's enables and mux selects.
module mips_mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] state,
  output logic       pc_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic       mem_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       alu_src_b,
  output logic [1:0] ext_op,
  output logic [2:0] alu_op,
  output logic [1:0] npc_sel,
  output logic       instr_done
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_NOP,
    C_ADDU,
    C_SUBU,
    C_JR,
    C_ORI,
    C_LUI,
    C_LW,
    C_SW,
    C_BEQ,
    C_J,
    C_JAL
  } iclass_t;

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       reg_we;
    logic       mem_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src_b;
    logic [1:0] ext_op;
    logic [2:0] alu_op;
    logic [1:0] npc_sel;
    logic       done;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] DST_RT   = 2'd0;
  localparam logic [1:0] DST_RD   = 2'd1;
  localparam logic [1:0] DST_RA   = 2'd2;

  localparam logic [1:0] WD_ALU   = 2'd0;
  localparam logic [1:0] WD_DM    = 2'd1;
  localparam logic [1:0] WD_PC4   = 2'd2;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;

  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JMP  = 2'd2;
  localparam logic [1:0] NPC_RS   = 2'd3;

  state_t  state_q;
  state_t  state_d;
  iclass_t iclass;
  ctrl_t   c;

  // Instruction classification; anything unrecognised (sll included) retires as a NOP.
  always_comb begin
    iclass = C_NOP;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: iclass = C_ADDU;
          FN_SUBU: iclass = C_SUBU;
          FN_JR:   iclass = C_JR;
          default: iclass = C_NOP;
        endcase
      end
      OP_J:    iclass = C_J;
      OP_JAL:  iclass = C_JAL;
      OP_BEQ:  iclass = C_BEQ;
      OP_ORI:  iclass = C_ORI;
      OP_LUI:  iclass = C_LUI;
      OP_LW:   iclass = C_LW;
      OP_SW:   iclass = C_SW;
      default: iclass = C_NOP;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block is given a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = S_FETCH;
    c       = '0;
    case (state_q)
      S_FETCH: begin
        c.ir_we = 1'b1;
        state_d = S_DECODE;
      end

      S_DECODE: begin
        case (iclass)
          C_J: begin
            c.pc_we   = 1'b1;
            c.npc_sel = NPC_JMP;
            c.done    = 1'b1;
            state_d   = S_FETCH;
          end
          C_JAL: begin
            c.pc_we   = 1'b1;
            c.npc_sel = NPC_JMP;
            c.reg_we  = 1'b1;
            c.reg_dst = DST_RA;
            c.wd_sel  = WD_PC4;
            c.done    = 1'b1;
            state_d   = S_FETCH;
          end
          C_JR: begin
            c.pc_we   = 1'b1;
            c.npc_sel = NPC_RS;
            c.done    = 1'b1;
            state_d   = S_FETCH;
          end
          C_NOP: begin
            c.pc_we   = 1'b1;
            c.npc_sel = NPC_PC4;
            c.done    = 1'b1;
            state_d   = S_FETCH;
          end
          default: state_d = S_EXEC;
        endcase
      end

      S_EXEC: begin
        case (iclass)
          C_ADDU: begin
            c.alu_op    = ALU_ADD;
            c.alu_src_b = 1'b0;
            state_d     = S_WB;
          end
          C_SUBU: begin
            c.alu_op    = ALU_SUB;
            c.alu_src_b = 1'b0;
            state_d     = S_WB;
          end
          C_ORI: begin
            c.alu_op    = ALU_OR;
            c.alu_src_b = 1'b1;
            c.ext_op    = EXT_ZERO;
            state_d     = S_WB;
          end
          C_LUI: begin
            c.alu_op    = ALU_OR;
            c.alu_src_b = 1'b1;
            c.ext_op    = EXT_LUI;
            state_d     = S_WB;
          end
          C_LW, C_SW: begin
            c.alu_op    = ALU_ADD;
            c.alu_src_b = 1'b1;
            c.ext_op    = EXT_SIGN;
            state_d     = S_MEM;
          end
          C_BEQ: begin
            c.alu_op    = ALU_SUB;
            c.alu_src_b = 1'b0;
            c.pc_we     = 1'b1;
            c.npc_sel   = zero ? NPC_BR : NPC_PC4;
            c.done      = 1'b1;
            state_d     = S_FETCH;
          end
          default: begin
            // Unreachable while IR is stable; retire cleanly rather than stall.
            c.pc_we = 1'b1;
            c.done  = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end

      S_MEM: begin
        // The DM address is the ALU sum, so the EXEC address selects stay up.
        c.alu_op    = ALU_ADD;
        c.alu_src_b = 1'b1;
        c.ext_op    = EXT_SIGN;
        case (iclass)
          C_SW: begin
            c.mem_we = 1'b1;
            c.pc_we  = 1'b1;
            c.done   = 1'b1;
            state_d  = S_FETCH;
          end
          C_LW:    state_d = S_WB;
          default: begin
            c.pc_we = 1'b1;
            c.done  = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end

      S_WB: begin
        c.pc_we   = 1'b1;
        c.npc_sel = NPC_PC4;
        c.done    = 1'b1;
        state_d   = S_FETCH;
        case (iclass)
          C_ADDU, C_SUBU: begin
            c.reg_we  = 1'b1;
            c.reg_dst = DST_RD;
            c.wd_sel  = WD_ALU;
          end
          C_ORI, C_LUI: begin
            c.reg_we  = 1'b1;
            c.reg_dst = DST_RT;
            c.wd_sel  = WD_ALU;
          end
          C_LW: begin
            c.reg_we  = 1'b1;
            c.reg_dst = DST_RT;
            c.wd_sel  = WD_DM;
          end
          default: c.reg_we = 1'b0;
        endcase
      end

      default: state_d = S_FETCH;
    endcase
  end

  // Reset masks every write strobe in the same cycle so an abandoned
  // instruction never commits anything while the state register recovers.
  assign state      = reset ? 3'd0 : state_q;
  assign pc_we      = c.pc_we  & ~reset;
  assign ir_we      = c.ir_we  & ~reset;
  assign reg_we     = c.reg_we & ~reset;
  assign mem_we     = c.mem_we & ~reset;
  assign instr_done = c.done   & ~reset;
  assign reg_dst    = c.reg_dst;
  assign wd_sel     = c.wd_sel;
  assign alu_src_b  = c.alu_src_b;
  assign ext_op     = c.ext_op;
  assign alu_op     = c.alu_op;
  assign npc_sel    = c.npc_sel;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: per-cycle output vectors for each instruction
// class, reset abandonment, and a random mixed stream with retirement counting.
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] state;
  logic       pc_we, ir_we, reg_we, mem_we;
  logic [1:0] reg_dst, wd_sel, ext_op, npc_sel;
  logic       alu_src_b;
  logic [2:0] alu_op;
  logic       instr_done;

  int n_checks = 0;
  int n_err    = 0;

  mips_mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .state(state), .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we), .mem_we(mem_we),
    .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src_b(alu_src_b), .ext_op(ext_op),
    .alu_op(alu_op), .npc_sel(npc_sel), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  logic [19:0] obs_vec;
  assign obs_vec = {state, pc_we, ir_we, reg_we, mem_we, reg_dst, wd_sel,
                    alu_src_b, ext_op, alu_op, npc_sel, instr_done};

  function automatic logic [19:0] pk(
    input logic [2:0] st, input logic pw, input logic iw, input logic rw,
    input logic mw, input logic [1:0] rd, input logic [1:0] wd, input logic sb,
    input logic [1:0] eo, input logic [2:0] ao, input logic [1:0] ns, input logic dn);
    return {st, pw, iw, rw, mw, rd, wd, sb, eo, ao, ns, dn};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the full output vector mid-cycle, then advance to just after the next edge.
  task automatic cyc(input string tag, input logic [19:0] exp);
    @(negedge clk);
    check(tag, {12'd0, obs_vec}, {12'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask

  logic [19:0] fetch_v;
  assign fetch_v = pk(3'd0, 0, 1, 0, 0, 2'd0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 0);

  logic [5:0] r_op [12];
  logic [5:0] r_fn [12];
  int         r_cy [12];

  initial begin
    int n_pc;
    int n_done;
    int n_coll;
    int n_instr;
    int idx;
    int cy;
    bit fin;

    reset = 1'b1;
    set_instr(6'h00, 6'h00);
    zero  = 1'b0;

    // Reset from power-up
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_enables", {27'd0, pc_we, ir_we, reg_we, mem_we, instr_done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // lw abandoned by reset in MEM
    set_instr(6'h23, 6'h00);
    cyc("lwr_fetch", fetch_v);
    cyc("lwr_decode", pk(3'd1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 0));
    cyc("lwr_exec", pk(3'd2, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd1, 3'd0, 2'd0, 0));
    reset = 1'b1;
    @(negedge clk);
    check("midrst_state", {29'd0, state}, 32'd0);
    check("midrst_enables", {27'd0, pc_we, ir_we, reg_we, mem_we, instr_done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // addu: 0,1,2,4
    set_instr(6'h00, 6'h21);
    cyc("addu_fetch", fetch_v);
    cyc("addu_decode", pk(3'd1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 0));
    cyc("addu_exec", pk(3'd2, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 0));
    cyc("addu_wb", pk(3'd4, 1, 0, 1, 0, 2'd1, 2'd0, 0, 2'd0, 3'd0, 2'd0, 1));

    // subu: EXEC selects sub
    set_instr(6'h00, 6'h23);
    cyc("subu_fetch", fetch_v);
    cyc("subu_decode", pk(3'd1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 0));
    cyc("subu_exec", pk(3'd2, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 3'd1, 2'd0, 0));
    cyc("subu_wb", pk(3'd4, 1, 0, 1, 0, 2'd1, 2'd0, 0, 2'd0, 3'd0, 2'd0, 1));

    // lw: 0,1,2,3,4
    set_instr(6'h23, 6'h00);
    cyc("lw_fetch", fetch_v);
    cyc("lw_decode", pk(3'd1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 0));
    cyc("lw_exec", pk(3'd2, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd1, 3'd0, 2'd0, 0));
    cyc("lw_mem", pk(3'd3, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd1, 3'd0, 2'd0, 0));
    cyc("lw_wb", pk(3'd4, 1, 0, 1, 0, 2'd0, 2'd1, 0, 2'd0, 3'd0, 2'd0, 1));

    // sw: 0,1,2,3
    set_instr(6'h2b, 6'h00);
    cyc("sw_fetch", fetch_v);
    cyc("sw_decode", pk(3'd1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 0));
    cyc("sw_exec", pk(3'd2, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd1, 3'd0, 2'd0, 0));
    cyc("sw_mem", pk(3'd3, 1, 0, 0, 1, 2'd0, 2'd0, 1, 2'd1, 3'd0, 2'd0, 1));

    // beq taken, then not taken
    set_instr(6'h04, 6'h00);
    zero = 1'b1;
    cyc("beqt_fetch", fetch_v);
    cyc("beqt_decode", pk(3'd1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 0));
    cyc("beqt_exec", pk(3'd2, 1, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 3'd1, 2'd1, 1));
    zero = 1'b0;
    cyc("beqn_fetch", fetch_v);
    cyc("beqn_decode", pk(3'd1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 0));
    cyc("beqn_exec", pk(3'd2, 1, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 3'd1, 2'd0, 1));

    // ori and lui
    set_instr(6'h0d, 6'h00);
    cyc("ori_fetch", fetch_v);
    cyc("ori_decode", pk(3'd1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 0));
    cyc("ori_exec", pk(3'd2, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd0, 3'd2, 2'd0, 0));
    cyc("ori_wb", pk(3'd4, 1, 0, 1, 0, 2'd0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 1));
    set_instr(6'h0f, 6'h00);
    cyc("lui_fetch", fetch_v);
    cyc("lui_decode", pk(3'd1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 0));
    cyc("lui_exec", pk(3'd2, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd2, 3'd2, 2'd0, 0));
    cyc("lui_wb", pk(3'd4, 1, 0, 1, 0, 2'd0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 1));

    // jal, jr, j
    set_instr(6'h03, 6'h00);
    cyc("jal_fetch", fetch_v);
    cyc("jal_decode", pk(3'd1, 1, 0, 1, 0, 2'd2, 2'd2, 0, 2'd0, 3'd0, 2'd2, 1));
    set_instr(6'h00, 6'h08);
    cyc("jr_fetch", fetch_v);
    cyc("jr_decode", pk(3'd1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 3'd0, 2'd3, 1));
    set_instr(6'h02, 6'h00);
    cyc("j_fetch", fetch_v);
    cyc("j_decode", pk(3'd1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 3'd0, 2'd2, 1));

    // NOPs: unknown opcode and sll
    set_instr(6'h3f, 6'h21);
    cyc("op3f_fetch", fetch_v);
    cyc("op3f_decode", pk(3'd1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 1));
    set_instr(6'h00, 6'h00);
    cyc("sll_fetch", fetch_v);
    cyc("sll_decode", pk(3'd1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 1));

    // Random mixed stream: cycle count per class, one pc_we and one done each
    r_op[0]  = 6'h00; r_fn[0]  = 6'h21; r_cy[0]  = 4;
    r_op[1]  = 6'h00; r_fn[1]  = 6'h23; r_cy[1]  = 4;
    r_op[2]  = 6'h00; r_fn[2]  = 6'h08; r_cy[2]  = 2;
    r_op[3]  = 6'h00; r_fn[3]  = 6'h00; r_cy[3]  = 2;
    r_op[4]  = 6'h0d; r_fn[4]  = 6'h00; r_cy[4]  = 4;
    r_op[5]  = 6'h0f; r_fn[5]  = 6'h00; r_cy[5]  = 4;
    r_op[6]  = 6'h23; r_fn[6]  = 6'h00; r_cy[6]  = 5;
    r_op[7]  = 6'h2b; r_fn[7]  = 6'h00; r_cy[7]  = 4;
    r_op[8]  = 6'h04; r_fn[8]  = 6'h00; r_cy[8]  = 3;
    r_op[9]  = 6'h02; r_fn[9]  = 6'h00; r_cy[9]  = 2;
    r_op[10] = 6'h03; r_fn[10] = 6'h00; r_cy[10] = 2;
    r_op[11] = 6'h3f; r_fn[11] = 6'h00; r_cy[11] = 2;

    n_pc    = 0;
    n_done  = 0;
    n_coll  = 0;
    n_instr = 40;
    for (int k = 0; k < n_instr; k++) begin
      idx = int'($urandom_range(0, 11));
      set_instr(r_op[idx], r_fn[idx]);
      zero = 1'($urandom_range(0, 1));
      cy  = 0;
      fin = 1'b0;
      while (!fin && cy < 8) begin
        @(negedge clk);
        cy++;
        if (pc_we)            n_pc++;
        if (instr_done)       n_done++;
        if (reg_we && mem_we) n_coll++;
        if (instr_done)       fin = 1'b1;
        @(posedge clk); #1;
      end
      check($sformatf("rnd%0d_op%0h_cycles", k, r_op[idx]), cy, r_cy[idx]);
    end
    check("rnd_pc_we_count", n_pc, n_instr);
    check("rnd_done_count", n_done, n_instr);
    check("rnd_we_collisions", n_coll, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multi-cycle control sequencer for the MIPS core. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every write enable and mux select of the shared datapath (PC, IR, GRF, ALU, DM). The top-level `mips` module instantiates it beside the datapath. Opcode and funct come from the datapath IR register, and zero comes from the ALU.

## Interface
- Parameters: none.
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; forces state to FETCH
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU result == 0 (valid in EXEC)
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
- pc_we  out  1  PC load from NPC this edge
- ir_we  out  1  IR load from IM this edge
- reg_we  out  1  GRF write this edge
- mem_we  out  1  DM write this edge
- reg_dst  out  2  0=rt, 1=rd, 2=$31
- wd_sel  out  2  0=ALU, 1=DM, 2=PC+4
- alu_src_b  out  1  0=rt data, 1=ext imm
- ext_op  out  2  0=zero-ext, 1=sign-ext, 2=lui (imm<<16)
- alu_op  out  3  0=add, 1=sub, 2=or
- npc_sel  out  2  0=PC+4, 1=branch, 2=j/jal target, 3=rs (jr)
- instr_done  out  1  high in final cycle of every instruction

## Operation
- Supported: addu, subu (R, op 0x00, funct 0x21/0x23), jr (funct 0x08), ori 0x0d, lui 0x0f, lw 0x23, sw 0x2b, beq 0x04, j 0x02, jal 0x03. Any other opcode/funct, including sll (nop), is a NOP.
- Outputs are combinational from state, opcode, funct, and zero. All enables and selects are 0 unless stated.
- FETCH: ir_we=1 -> DECODE.
- DECODE (operands read, no enables except below):
  - j: pc_we=1, npc_sel=2, done -> FETCH.
  - jal: pc_we=1, npc_sel=2, reg_we=1, reg_dst=2, wd_sel=2, done -> FETCH.
  - jr: pc_we=1, npc_sel=3, done -> FETCH.
  - NOP/unknown: pc_we=1, npc_sel=0, done -> FETCH.
  - otherwise -> EXEC.
- EXEC: selects held for ALU:
  - addu: alu_op=0, src_b=0.
  - subu: alu_op=1, src_b=0.
  - ori: alu_op=2, src_b=1, ext_op=0.
  - lui: alu_op=2, src_b=1, ext_op=2.
  - lw/sw: alu_op=0, src_b=1, ext_op=1.
  - beq: alu_op=1, src_b=0, pc_we=1, npc_sel = zero ? 1 : 0, done -> FETCH.
  - lw/sw -> MEM; R/ori/lui -> WB.
- MEM: address selects held as EXEC.
  - sw: mem_we=1, pc_we=1, npc_sel=0, done -> FETCH.
  - lw -> WB.
- WB: reg_we=1, pc_we=1, npc_sel=0, done -> FETCH.
  - R: reg_dst=1, wd_sel=0.
  - ori/lui: reg_dst=0, wd_sel=0.
  - lw: reg_dst=0, wd_sel=1.
- Exactly one pc_we pulse per instruction, always coincident with instr_done.
- reg_we and mem_we are never high in the same cycle.

## Timing
- Cycles per instruction:
  - j, jal, jr, NOP: 2.
  - beq: 3.
  - R, ori, lui, sw: 4.
  - lw: 5.
- Reset:
  - With reset high at an edge, the next state is FETCH regardless of the current state. An instruction in progress is abandoned and PC is not advanced.
  - While reset is high, pc_we, ir_we, reg_we, and mem_we are forced 0, instr_done=0, and state output reads 0.
- First FETCH (ir_we=1) occurs in the first cycle after reset deasserts.
- Writes (PC, IR, GRF, DM) take effect on the rising edge that ends the cycle in which the enable is high.
- opcode/funct are stable from DECODE through the final state because IR loads only in FETCH.
- zero is sampled combinationally in EXEC only.

## Test plan
- Reset in the middle of lw MEM, held 1 cycle -> state=0, no mem_we/reg_we/pc_we asserted during reset, FETCH ir_we=1 the next cycle.
- addu (op 0, funct 0x21) -> state trace 0,1,2,4,0. WB has reg_we=1, reg_dst=1, wd_sel=0, pc_we=1, npc_sel=0. instr_done high in WB only.
- lw then sw -> lw trace 0,1,2,3,4 with WB wd_sel=1. sw trace 0,1,2,3 with MEM mem_we=1, ext_op=1, and no reg_we.
- beq with zero=1, then beq with zero=0 -> 3 cycles each. EXEC has npc_sel=1 and npc_sel=0 respectively, pc_we=1.
- jal then jr -> jal DECODE has reg_we=1, reg_dst=2, wd_sel=2, npc_sel=2. jr DECODE has npc_sel=3 and reg_we=0. 2 cycles each.
- Opcode 0x3f and sll (op 0, funct 0) -> 2-cycle NOP, npc_sel=0, no reg_we/mem_we. Over a random mixed stream, count(pc_we) equals count(instr_done) equals the instruction count.
